// File: rtl/writeback_stage.sv
// Writeback: buffers retiring instructions and drives the regfile write port; write strobe is
// combinational from the FIFO head. in_ready drops only when the FIFO is full, and ECALLs stall the head.
module writeback_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_load_data,
  input  logic [2:0]  in_addr_low,
  input  logic        in_is_ecall,
  output logic        write_enable,
  output logic [4:0]  write_register,
  output logic [63:0] write_value,
  input  logic        write_ready,
  output logic        ecall,
  input  logic        ecall_done,
  output logic [31:0] retire_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_ECALL_WAIT = 2'd1;
  localparam logic [1:0] ST_ECALL_GAP  = 2'd2;

  logic [4:0]    rd_mem  [FIFO_DEPTH];
  logic [63:0]   val_mem [FIFO_DEPTH];
  logic          ec_mem  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [1:0]    state, state_next;

  logic          empty, push, pop, run_write;
  logic [4:0]    head_rd;
  logic [63:0]   head_val;
  logic          head_ec;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_w;
  logic [63:0]   enq_val;

  // Narrower accesses ignore the low offset bits, so H/W always land on natural boundaries.
  always_comb begin
    ld_b = in_load_data[{in_addr_low, 3'b000} +: 8];
    ld_h = in_load_data[{in_addr_low[2:1], 4'b0000} +: 16];
    ld_w = in_load_data[{in_addr_low[2], 5'b00000} +: 32];
    enq_val = in_result;
    if (in_is_load) begin
      case (in_funct3)
        3'd0:    enq_val = {{56{ld_b[7]}}, ld_b};
        3'd1:    enq_val = {{48{ld_h[15]}}, ld_h};
        3'd2:    enq_val = {{32{ld_w[31]}}, ld_w};
        3'd4:    enq_val = {56'd0, ld_b};
        3'd5:    enq_val = {48'd0, ld_h};
        3'd6:    enq_val = {32'd0, ld_w};
        default: enq_val = in_load_data;
      endcase
    end
  end

  always_comb begin
    empty     = (count == '0);
    head_rd   = rd_mem[rd_ptr];
    head_val  = val_mem[rd_ptr];
    head_ec   = ec_mem[rd_ptr];
    in_ready  = reset || (count < DEPTH_C);
    push      = in_valid && in_ready && !reset;
    run_write = !reset && (state == ST_RUN) && !empty && !head_ec;
    pop       = !reset && ((run_write && write_ready) ||
                           ((state == ST_ECALL_WAIT) && ecall_done));
    write_enable   = run_write && (head_rd != 5'd0);
    write_register = write_enable ? head_rd : 5'd0;
    write_value    = write_enable ? head_val : 64'd0;

    state_next = state;
    case (state)
      ST_RUN:        if (!empty && head_ec) state_next = ST_ECALL_WAIT;
      ST_ECALL_WAIT: if (ecall_done) state_next = ST_ECALL_GAP;
      ST_ECALL_GAP:  state_next = ST_RUN;
      default:       state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]  <= in_rd;
      val_mem[wr_ptr] <= enq_val;
      ec_mem[wr_ptr]  <= in_is_ecall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      state        <= ST_RUN;
      ecall        <= 1'b0;
      retire_count <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      state <= state_next;
      // Registered so the regfile sees a clean level for the whole wait.
      ecall <= (state_next == ST_ECALL_WAIT);
      if (pop) retire_count <= retire_count + 32'd1;
    end
  end

endmodule
